instr_fetch: RTL and testbench

// - Fetch stage directly upstream of main_control.
// - Owns the PC and issues in-order read requests to instruction memory over a valid/ready handshake.
// - Buffers the returned instructions in a small FIFO.
// - Presents one instruction at a time to decode, together with its PC, decoded op_type and valid_op.
// - Branch/jump redirects flush the FIFO. Responses still in flight for the old path are discarded.

---
 rtl/instr_fetch_pkg.sv | 49 ++++
 rtl/instr_fetch_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared RISC-V fetch/decode definitions: opcode classes, reset constants and
// the opcode classifier used by both fetch and decode.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [3:0] {
    LOAD,
    STORE,
    BRANCH,
    JALR,
    JAL,
    OP_IMM,
    OP,
    LUI,
    AUIPC,
    SYSTEM,
    MISC_MEM
  } op_type;

  typedef struct packed {
    op_type optype;
    logic   legal;
  } dec_t;

  // Unknown opcodes (including any with instr[1:0] != 2'b11) report OP_IMM, illegal.
  function automatic dec_t decode_optype(input logic [6:0] opc);
    dec_t d;
    d.optype = OP_IMM;
    d.legal  = 1'b1;
    case (opc)
      7'b0000011: d.optype = LOAD;
      7'b0100011: d.optype = STORE;
      7'b1100011: d.optype = BRANCH;
      7'b1100111: d.optype = JALR;
      7'b1101111: d.optype = JAL;
      7'b0010011: d.optype = OP_IMM;
      7'b0110011: d.optype = OP;
      7'b0110111: d.optype = LUI;
      7'b0010111: d.optype = AUIPC;
      7'b1110011: d.optype = SYSTEM;
      7'b0001111: d.optype = MISC_MEM;
      default:    d.legal  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO with flush; the head entry is read straight from the
// storage registers so consumers see no path from the write side.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  // A pop frees the slot in the same cycle, so push+pop is legal when full.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order credit-limited reads, buffers the
// returned words and discards responses belonging to a redirected-away path.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output op_type      out_optype,
  output logic        out_valid_op
);

  localparam int OCC_W = CNT_W + 1;

  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_fetch_en;

  logic             w_req_hs;
  logic             w_rsp_ok;
  logic             w_rsp_keep;
  logic             w_rsp_drop;
  logic             w_bypass;
  logic [31:0]      w_rsp_pc;
  logic [OCC_W-1:0] w_occ;
  logic [63:0]      w_head;
  logic [CNT_W-1:0] w_data_count;
  logic             w_data_empty;
  logic [31:0]      w_tag_dout;
  logic [CNT_W-1:0] w_tag_count;
  logic             w_tag_empty;
  dec_t             w_dec;

  // Valid/ready: a transfer happens on a cycle where both are high; the
  // request address is held unchanged while valid waits for ready.
  assign w_occ          = {1'b0, r_outstanding} + {1'b0, w_data_count};
  assign imem_req_valid = r_fetch_en && !redirect_valid && (w_occ < OCC_W'(FIFO_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_hs       = imem_req_valid && imem_req_ready;

  // A same-cycle request counts, so zero-latency memories are accepted.
  assign w_rsp_ok   = imem_rsp_valid && ((r_outstanding != '0) || w_req_hs);
  assign w_rsp_keep = w_rsp_ok && (r_drop_cnt == '0);
  assign w_rsp_drop = w_rsp_ok && (r_drop_cnt != '0);
  assign w_bypass   = w_rsp_keep && w_tag_empty;
  assign w_rsp_pc   = w_tag_empty ? r_pc : w_tag_dout;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32), .CW(CNT_W)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_req_hs && !w_bypass),
    .i_din   (r_pc),
    .i_pop   (w_rsp_keep && !w_tag_empty),
    .o_dout  (w_tag_dout),
    .o_count (w_tag_count),
    .o_empty (w_tag_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64), .CW(CNT_W)) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_rsp_keep && !redirect_valid),
    .i_din   ({imem_rsp_data, w_rsp_pc}),
    .i_pop   (out_valid && out_ready),
    .o_dout  (w_head),
    .o_count (w_data_count),
    .o_empty (w_data_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_en    <= 1'b0;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_fetch_en    <= 1'b1;
      r_outstanding <= r_outstanding + CNT_W'(w_req_hs) - CNT_W'(w_rsp_ok);
      if (redirect_valid) begin
        r_pc       <= redirect_pc & ~32'h3;
        r_drop_cnt <= r_outstanding - CNT_W'(w_rsp_ok);
      end else begin
        if (w_req_hs)   r_pc       <= r_pc + 32'd4;
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  assign w_dec        = decode_optype(w_head[38:32]);
  assign out_valid    = !w_data_empty;
  assign out_instr    = out_valid ? w_head[63:32] : NOP_INSTR;
  assign out_pc       = out_valid ? w_head[31:0]  : 32'h0;
  assign out_optype   = out_valid ? w_dec.optype  : OP_IMM;
  assign out_valid_op = out_valid && w_dec.legal;

  a_rsp_protocol: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((r_outstanding != '0) || w_req_hs));

  a_tag_tracks: assert property (@(posedge clk) disable iff (rst)
    w_tag_count == (r_outstanding - r_drop_cnt));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch against a path-level model: sequential PCs
// from the last redirect, a memory queue of accepted requests, fixed contents.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  op_type      out_optype;
  logic        out_valid_op;

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_optype     (out_optype),
    .out_valid_op   (out_valid_op)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_out_pc;
  logic [31:0] exp_req_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [6:0] opc;
    if (addr == 32'h8) return 32'h0000_0000;
    if (addr == 32'hC) return 32'h0000_0003;
    case (addr[4:2])
      3'd0: opc = 7'h13;
      3'd1: opc = 7'h33;
      3'd2: opc = 7'h03;
      3'd3: opc = 7'h23;
      3'd4: opc = 7'h63;
      3'd5: opc = 7'h6f;
      3'd6: opc = 7'h7f;
      default: opc = 7'h37;
    endcase
    return {addr[26:2], opc};
  endfunction

  // RISC-V base opcode map.
  function automatic void ref_decode(input logic [6:0] opc, output op_type t, output logic legal);
    legal = 1'b1;
    t = OP_IMM;
    case (opc)
      7'h03: t = LOAD;
      7'h23: t = STORE;
      7'h63: t = BRANCH;
      7'h67: t = JALR;
      7'h6f: t = JAL;
      7'h13: t = OP_IMM;
      7'h33: t = OP;
      7'h37: t = LUI;
      7'h17: t = AUIPC;
      7'h73: t = SYSTEM;
      7'h0f: t = MISC_MEM;
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic check_outputs();
    op_type      t;
    logic        legal;
    logic [31:0] w;
    if (out_valid) begin
      w = mem_word(exp_out_pc);
      ref_decode(w[6:0], t, legal);
      check("out_pc", out_pc, exp_out_pc);
      check("out_instr", out_instr, w);
      check("out_optype", 32'(out_optype), 32'(t));
      check("out_valid_op", 32'(out_valid_op), 32'(legal));
    end else begin
      check("idle_instr", out_instr, NOP_INSTR);
      check("idle_pc", out_pc, 32'h0);
      check("idle_optype", 32'(out_optype), 32'(OP_IMM));
      check("idle_valid_op", 32'(out_valid_op), 32'h0);
    end
  endtask

  task automatic drive(input bit redir, input logic [31:0] tgt, input bit o_rdy,
                       input bit r_rdy, input bit rsp_en);
    redirect_valid = redir;
    redirect_pc    = tgt;
    out_ready      = o_rdy;
    imem_req_ready = r_rdy;
    #1;
    if (redir) check("req_blocked", 32'(imem_req_valid), 32'h0);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
    if (imem_req_valid && r_rdy) begin
      exp_q.push_back(imem_req_addr);
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (rsp_en && exp_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(exp_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (out_valid && o_rdy) begin
      exp_out_pc = exp_out_pc + 32'd4;
      n_pops++;
    end
    if (redir) begin
      exp_out_pc = tgt & ~32'h3;
      exp_req_pc = tgt & ~32'h3;
    end
    check("credit_inflight", 32'(exp_q.size() <= DEPTH), 32'h1);
    check("credit_path", 32'(((exp_req_pc - exp_out_pc) >> 2) <= DEPTH), 32'h1);
  endtask

  task automatic cycle(input bit redir, input logic [31:0] tgt, input bit o_rdy,
                       input bit r_rdy, input bit rsp_en);
    @(negedge clk);
    check_outputs();
    drive(redir, tgt, o_rdy, r_rdy, rsp_en);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    check({tag, "_req_addr"}, imem_req_addr, 32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_instr"}, out_instr, NOP_INSTR);
    check({tag, "_out_pc"}, out_pc, 32'h0);
    check({tag, "_out_optype"}, 32'(out_optype), 32'(OP_IMM));
    check({tag, "_out_valid_op"}, 32'(out_valid_op), 32'h0);
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic [31:0] stall_addr;
    bit          saw_target;

    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    exp_out_pc     = 32'h0;
    exp_req_pc     = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming with zero-latency memory: one instruction per cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_outputs();
      if (i >= 2) begin
        check("stream_valid", 32'(out_valid), 32'h1);
        check("stream_pc", out_pc, 32'(4 * (i - 2)));
      end
      if (i == 4) check("illegal_valid_op", 32'(out_valid_op), 32'h0);
      if (i == 5) begin
        check("load_optype", 32'(out_optype), 32'(LOAD));
        check("load_valid_op", 32'(out_valid_op), 32'h1);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (i >= 1 && i <= 3) check("req_seq", imem_req_addr, 32'(4 * (i - 1)));
    end

    // Decode stalls for 10 cycles: head holds, credits cap the inflight count.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_outputs();
      if (i == 0) begin
        hold_pc    = exp_out_pc;
        hold_instr = mem_word(exp_out_pc);
      end
      check("stall_pc", out_pc, hold_pc);
      check("stall_instr", out_instr, hold_instr);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    end
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Redirect with two requests outstanding: both stale responses dropped.
    repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("two_outstanding", 32'(exp_q.size()), 32'd2);
    cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    saw_target = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_outputs();
      if (out_valid && out_pc == 32'h100) saw_target = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    end
    check("redirect_target_seen", 32'(saw_target), 32'h1);

    // Redirect coinciding with a response handshake and a pop.
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_outputs();
    check("coinc_pre_valid", 32'(out_valid), 32'h1);
    check("coinc_pre_inflight", 32'(exp_q.size()), 32'd1);
    drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_outputs();
    check("coinc_flushed", 32'(out_valid), 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_outputs();
    check("coinc_no_drop_valid", 32'(out_valid), 32'h1);
    check("coinc_no_drop_pc", out_pc, 32'h200);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Memory not ready: address holds until the handshake.
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    stall_addr = exp_req_pc;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_outputs();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      if (i >= 3) begin
        check("nrdy_req_valid", 32'(imem_req_valid), 32'h1);
        check("nrdy_req_addr", imem_req_addr, stall_addr);
      end
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check("nrdy_advance", exp_req_pc, stall_addr + 32'd4);
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Random traffic with occasional redirects.
    n_pops = 0;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 3), $urandom,
            ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 75),
            ($urandom_range(0, 99) < 60));
    end
    check("random_progress", 32'(n_pops >= 30), 32'h1);

    // Asynchronous reset in the middle of a burst.
    repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_values("async");
    exp_q.delete();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    exp_out_pc = 32'h0;
    exp_req_pc = 32'h0;
    @(posedge clk);
    #1 rst = 1'b0;
    saw_target = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_outputs();
      if (out_valid && out_pc == 32'h0) saw_target = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    end
    check("restart_from_reset_pc", 32'(saw_target), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
